// File: rtl/cla_seq_adder_ctrl.sv
// Sequenced WIDTH-bit adder: one shared 4-bit CLA slice processes a nibble per cycle, LSB first.
// Optional build macro CLA_SEQ_SUB_EN adds the in_sub port (A-B mode); the default build is add-only.

module cla_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  // Carry look-ahead: every carry is a flat function of generate/propagate and cin.
  always_comb begin
    w_g    = i_a & i_b;
    w_p    = i_a ^ i_b;
    w_c[0] = i_cin;
    w_c[1] = w_g[0] | (w_p[0] & i_cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
    o_sum  = w_p ^ w_c[3:0];
    o_cout = w_c[4];
  end
endmodule

module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;
  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;

  // Operand-B / carry-in as latched at accept; subtraction is A + ~B + 1.
  always_comb begin
`ifdef CLA_SEQ_SUB_EN
    if (in_sub) begin
      w_b_load   = ~in_b;
      w_cin_load = 1'b1;
    end else begin
      w_b_load   = in_b;
      w_cin_load = in_cin;
    end
`else
    w_b_load   = in_b;
    w_cin_load = in_cin;
`endif
  end

  // Select the current nibble by shifting the operand registers down.
  always_comb begin
    w_a_shift = r_a >> {r_idx, 2'b00};
    w_b_shift = r_b >> {r_idx, 2'b00};
  end

  cla_4bit u_slice (
    .i_a    (w_a_shift[3:0]),
    .i_b    (w_b_shift[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign busy      = r_busy;

  // Control FSM with its registered datapath and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= {IDXW{1'b0}};
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= w_b_load;
            r_carry <= w_cin_load;
            r_idx   <= {IDXW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDXW'(n)) begin
              r_sum[4*n +: 4] <= w_slice_sum;
            end
          end
          r_carry <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            r_idx       <= {IDXW{1'b0}};
            r_cout      <= w_slice_cout;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          // New operands are never taken here, even if out_ready and in_valid coincide.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule
